// File: rtl/sevenseg_encoder.sv
// ---------------------------------------------------------------------------
// sevenseg_encoder
//   Recovers a hex digit from a 7-segment pattern (the inverse of the HEX0
//   decoder). seg_in is asynchronous, so it is synchronised, debounced and
//   then matched exactly against the 16 canonical glyphs. A recovered digit
//   is offered on a valid/ready handshake. A stable pattern that matches no
//   glyph raises a one-cycle error pulse instead.
//
//   Optional feature macro: SEG_ERRCNT_EN (adds a saturating error counter;
//   without it err_count is tied to zero).
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   seg_in     [6:0] segment pattern, bit0=a(top) .. bit6=g(middle), async
//   hex_ready  consumer accepts hex_out this cycle
//   hex_out    [3:0] recovered digit
//   hex_valid  hex_out holds a digit not yet accepted
//   err_pulse  one-cycle pulse: stable pattern matched no glyph
//   err_count  [7:0] invalid-pattern count (0 unless SEG_ERRCNT_EN)
// ---------------------------------------------------------------------------
module sevenseg_encoder #(
    parameter int STABLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       hex_ready,
    output logic [3:0] hex_out,
    output logic       hex_valid,
    output logic       err_pulse,
    output logic [7:0] err_count
);

    localparam int            CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] STABLE_N = CW'(STABLE_CYCLES);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONVERT = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    // Active-high glyphs, g..a; entry [n] is the pattern for digit n.
    localparam logic [15:0][6:0] GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    logic [6:0]    sync1, sync2;
    logic [1:0]    sync_vld;
    logic [6:0]    seg_s, seg_prev, cand;
    logic [CW-1:0] run_cnt, run_nxt;
    logic          stable;
    logic [7:0]    last_conv;
    logic [1:0]    state;
    logic [15:0]   hit;
    logic          match;
    logic [3:0]    match_idx;

    // ---------------- synchroniser ----------------
    // sync_vld marks when sync2 carries real samples rather than reset zeros;
    // otherwise the reset value (all-on "8" when active-low) could convert.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            sync_vld <= '0;
        end else begin
            sync1    <= seg_in;
            sync2    <= sync1;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    assign seg_s = ACTIVE_LOW ? ~sync2 : sync2;

    // ---------------- stability tracking ----------------
    // run_nxt is the length of the current run of identical samples,
    // including the one now in sync2. Deciding on it directly (rather than
    // on the registered count) gives the step-to-valid latency of
    // STABLE_CYCLES+3 edges.
    always_comb begin
        run_nxt = '0;
        if (sync_vld[1]) begin
            if (seg_s != seg_prev)
                run_nxt = CW'(1);
            else if (run_cnt == STABLE_N)
                run_nxt = STABLE_N;
            else
                run_nxt = run_cnt + 1'b1;
        end
    end

    assign stable = (run_nxt == STABLE_N);

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_prev <= '0;
            run_cnt  <= '0;
        end else begin
            seg_prev <= seg_s;
            run_cnt  <= run_nxt;
        end
    end

    // ---------------- glyph match ----------------
    for (genvar g = 0; g < 16; g++) begin : g_match
        assign hit[g] = (cand == GLYPHS[g]);
    end

    always_comb begin
        match_idx = '0;
        for (int i = 0; i < 16; i++)
            if (hit[i]) match_idx = 4'(i);
    end

    assign match = |hit;

    // ---------------- FSM ----------------
    // The pattern is captured on IDLE->CONVERT so a change on the very next
    // sample cannot corrupt the conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= '0;
            last_conv <= 8'h80;
            hex_out   <= '0;
            hex_valid <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (stable && ({1'b0, seg_s} != last_conv)) begin
                        cand  <= seg_s;
                        state <= CONVERT;
                    end
                end
                CONVERT: begin
                    last_conv <= {1'b0, cand};
                    if (match) begin
                        hex_out   <= match_idx;
                        hex_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        err_pulse <= 1'b1;
                        state     <= IDLE;
                    end
                end
                HOLD: begin
                    if (hex_ready) begin
                        hex_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- optional error counter ----------------
`ifdef SEG_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            err_cnt_q <= '0;
        else if (err_pulse && (err_cnt_q != 8'hFF))
            err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule
